// File: rtl/myproject_mul_arb_pkg.sv
// Shared widths, operand/product types and ID width helper for the shared-DSP multiply arbiter.
// Consumed by myproject_mul_arb and its grant picker.
package myproject_mul_arb_pkg;

  localparam int A_W       = 16;
  localparam int B_W       = 8;
  localparam int P_W       = A_W + B_W;
  localparam int N_REQ_MAX = 8;

  typedef logic signed [A_W-1:0] operand_a_t;
  typedef logic signed [B_W-1:0] operand_b_t;
  typedef logic signed [P_W-1:0] product_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/myproject_mul_arb_pick.sv
// Grant picker: one-hot grant among valid requesters, zero when en is low; combinational.
// Round-robin from ptr when MUL_ARB_RR_EN is defined, otherwise lowest index wins and ptr is ignored.
module myproject_mul_arb_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]  ptr,
  input  logic             en,
  output logic [N_REQ-1:0] grant
);

`ifdef MUL_ARB_RR_EN
  logic            found;
  logic [ID_W-1:0] idx;

  // Scan starts at the pointer and wraps modulo N_REQ.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % N_REQ);
      if (en && !found && req_valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
`else
  logic found;
  logic ptr_unused;

  assign ptr_unused = ^ptr;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (en && !found && req_valid[k]) begin
        grant[k] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/myproject_mul_arb.sv
// Arbitrates N_REQ requesters onto one 16s x 8s -> 24s multiply, result tagged with requester id (MUL_ARB_RR_EN selects round-robin).
// Latency 2 cycles from accept to res_valid; one result per cycle; at most 2 operations in flight.
// Backpressure: res_ready low freezes S2, then S1; req_ready drops to zero once both stages are full.
module myproject_mul_arb
  import myproject_mul_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst_n,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ*A_W-1:0]          req_a,
  input  logic [N_REQ*B_W-1:0]          req_b,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [id_width(N_REQ)-1:0]    res_id,
  output logic [P_W-1:0]                res_p
);

  localparam int ID_W = id_width(N_REQ);

  logic            s1_vld, s2_vld;
  operand_a_t      s1_a;
  operand_b_t      s1_b;
  logic [ID_W-1:0] s1_id, s2_id;
  product_t        s2_p;
  product_t        mul_p;

  logic            adv1, adv2;
  logic            grant_en;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0] gidx;
  operand_a_t      sel_a;
  operand_b_t      sel_b;
  logic [ID_W-1:0] ptr;

  assign adv2 = !s2_vld || res_ready;
  assign adv1 = !s1_vld || adv2;

  // Reset gates the grant so no requester sees a handshake while the pipe is being cleared.
  assign grant_en = adv1 && ap_rst_n;

  myproject_mul_arb_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req_valid (req_valid),
    .ptr       (ptr),
    .en        (grant_en),
    .grant     (grant)
  );

  assign req_ready = grant;

  always_comb begin
    gidx  = '0;
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        gidx  = ID_W'(i);
        sel_a = req_a[i*A_W +: A_W];
        sel_b = req_b[i*B_W +: B_W];
      end
    end
  end

`ifdef MUL_ARB_RR_EN
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ptr <= '0;
    end else if (|grant) begin
      ptr <= (gidx == ID_W'(N_REQ - 1)) ? '0 : gidx + 1'b1;
    end
  end
`else
  assign ptr = '0;
`endif

  // Both operands widened to the product width so the multiply is exact and maps to one DSP.
  assign mul_p = product_t'(s1_a) * product_t'(s1_b);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s1_vld <= 1'b0;
      s1_a   <= '0;
      s1_b   <= '0;
      s1_id  <= '0;
      s2_vld <= 1'b0;
      s2_p   <= '0;
      s2_id  <= '0;
    end else begin
      if (adv1) begin
        s1_vld <= |grant;
        if (|grant) begin
          s1_a  <= sel_a;
          s1_b  <= sel_b;
          s1_id <= gidx;
        end
      end
      if (adv2) begin
        s2_vld <= s1_vld;
        if (s1_vld) begin
          s2_p  <= mul_p;
          s2_id <= s1_id;
        end
      end
    end
  end

  assign res_valid = s2_vld;
  assign res_id    = s2_id;
  assign res_p     = s2_p;

endmodule

// File: tb/tb_myproject_mul_arb.sv
// Directed bench for myproject_mul_arb: corner products, full load, back-pressure, reset, sparse traffic.
// Expected grant orders follow MUL_ARB_RR_EN; results are scoreboarded in grant order.
module tb_myproject_mul_arb;
  import myproject_mul_arb_pkg::*;

  localparam int N = 4;

  logic             ap_clk = 1'b0;
  logic             ap_rst_n = 1'b1;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*A_W-1:0] req_a;
  logic [N*B_W-1:0] req_b;
  logic             res_valid;
  logic             res_ready;
  logic [1:0]       res_id;
  logic [P_W-1:0]   res_p;

  int errors = 0;
  int checks = 0;

  operand_a_t op_a [N];
  operand_b_t op_b [N];

  typedef struct packed {
    logic [1:0]  id;
    logic [23:0] p;
  } res_t;
  res_t exp_q[$];

  typedef struct {
    int          idx;
    logic [15:0] a;
    logic [7:0]  b;
    logic [23:0] exp_p;
  } vec_t;
  vec_t vt [6];

  always #5 ap_clk = ~ap_clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_pack
    assign req_a[gi*A_W +: A_W] = op_a[gi];
    assign req_b[gi*B_W +: B_W] = op_b[gi];
  end

  myproject_mul_arb #(.N_REQ(N)) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_p     (res_p)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] golden(input operand_a_t a, input operand_b_t b);
    int r;
    r = int'(a) * int'(b);
    return r[23:0];
  endfunction

  // Called just after a rising edge; returns the handshakes of the cycle and advances one clock.
  task automatic step(input logic [N-1:0] vld, output logic [N-1:0] acc);
    req_valid = vld;
    #1;
    acc = req_valid & req_ready;
    check("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
    for (int i = 0; i < N; i++)
      if (acc[i]) exp_q.push_back('{id: 2'(i), p: golden(op_a[i], op_b[i])});
    @(posedge ap_clk);
    #1;
  endtask

  // Scoreboard: every transferred result must be the next expected one.
  always @(negedge ap_clk) begin
    res_t r;
    if (ap_rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_result: got id=%0d p=0x%0h, expected no result", res_id, res_p);
      end else begin
        r = exp_q.pop_front();
        check("result", {6'd0, res_id, res_p}, {6'd0, r.id, r.p});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] acc;
    int           lat, n, cyc, w, naccept, who;
    int           cnt [N];
    int           gseq [12];
    logic [31:0]  hold;

    vt[0] = '{2, 16'h8000, 8'h80, 24'h400000};
    vt[1] = '{1, 16'h7FFF, 8'hFF, 24'hFF8001};
    vt[2] = '{0, 16'd100,  8'd3,  24'h00012C};
    vt[3] = '{3, 16'hFFFB, 8'd7,  24'hFFFFDD};
    vt[4] = '{0, 16'h7FFF, 8'h7F, 24'h3F7F81};
    vt[5] = '{3, 16'h8000, 8'h7F, 24'hC08000};
`ifdef MUL_ARB_RR_EN
    gseq = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
`else
    gseq = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
`endif

    for (int i = 0; i < N; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    req_valid = '1;
    res_ready = 1'b0;
    #1 ap_rst_n = 1'b0;
    #2;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_id",    32'(res_id),    32'd0);
    check("rst_res_p",     32'(res_p),     32'd0);
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst_n  = 1'b1;
    req_valid = '0;

    // Single operations with hand-computed corner products and latency.
    res_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      op_a[vt[j].idx] = vt[j].a;
      op_b[vt[j].idx] = vt[j].b;
      step(4'(1 << vt[j].idx), acc);
      check("single_grant", 32'(acc), 32'(1 << vt[j].idx));
      lat = 1;
      while (!res_valid && lat < 8) begin
        step('0, acc);
        lat++;
      end
      check("single_latency", 32'(lat), 32'd2);
      check("single_p",  32'(res_p),  32'(vt[j].exp_p));
      check("single_id", 32'(res_id), 32'(vt[j].idx));
    end
    repeat (2) step('0, acc);

    // Full load: each requester offers 3 ops, one grant per cycle.
    for (int i = 0; i < N; i++) cnt[i] = 0;
    n = 0;
    cyc = 0;
    while (n < 12 && cyc < 40) begin
      for (int i = 0; i < N; i++) begin
        op_a[i] = operand_a_t'(i * 4099 - 20000 + cnt[i] * 777);
        op_b[i] = operand_b_t'(i * 37 - 60 + cnt[i] * 11);
      end
      step({cnt[3] < 3, cnt[2] < 3, cnt[1] < 3, cnt[0] < 3}, acc);
      cyc++;
      check("full_grant", 32'(acc), 32'(1 << gseq[n]));
      for (int i = 0; i < N; i++)
        if (acc[i]) begin
          cnt[i]++;
          n++;
        end
    end
    check("full_cycles", 32'(cyc), 32'd12);
    repeat (3) step('0, acc);
    check("full_drain", 32'(exp_q.size()), 32'd0);

    // Back-pressure: downstream stalled for 5 cycles.
    for (int i = 0; i < N; i++) begin
      op_a[i] = operand_a_t'($urandom);
      op_b[i] = operand_b_t'($urandom);
    end
    res_ready = 1'b0;
    naccept = 0;
    hold = '0;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        check("bp_valid", 32'(res_valid), 32'd1);
        hold = {6'd0, res_id, res_p};
        check("bp_front", hold, {6'd0, exp_q[0].id, exp_q[0].p});
      end
      if (c > 2) check("bp_hold", {6'd0, res_id, res_p}, hold);
      step('1, acc);
      if (c >= 2) check("bp_ready_zero", 32'(acc), 32'd0);
      naccept += $countones(acc);
      for (int i = 0; i < N; i++)
        if (acc[i]) begin
          op_a[i] = operand_a_t'($urandom);
          op_b[i] = operand_b_t'($urandom);
        end
    end
    check("bp_accepts", 32'(naccept), 32'd2);
    res_ready = 1'b1;
    repeat (4) step('0, acc);
    check("bp_drain", 32'(exp_q.size()), 32'd0);

    // Reset with two operations in flight.
    res_ready = 1'b0;
    step('1, acc);
    step('1, acc);
    ap_rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_valid", 32'(res_valid), 32'd0);
    check("mid_rst_id",    32'(res_id),    32'd0);
    check("mid_rst_p",     32'(res_p),     32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst_n  = 1'b1;
    res_ready = 1'b1;
    step('1, acc);
    check("post_rst_grant", 32'(acc), 32'd1);
    repeat (3) step('0, acc);
    check("post_rst_drain", 32'(exp_q.size()), 32'd0);

    // Sparse: requesters 3 and 1 alternate with idle gaps.
    for (int k = 0; k < 4; k++) begin
      who = (k % 2 == 0) ? 3 : 1;
      op_a[who] = operand_a_t'(k * 1234 - 3000);
      op_b[who] = operand_b_t'(k * 29 - 50);
      repeat (2) step('0, acc);
      w = 0;
      acc = '0;
      while (acc == '0 && w < 10) begin
        step(4'(1 << who), acc);
        w++;
      end
      check("sparse_wait", 32'(w <= N), 32'd1);
      check("sparse_grant", 32'(acc), 32'(1 << who));
    end
    step('1, acc);
`ifdef MUL_ARB_RR_EN
    check("sparse_ptr_grant", 32'(acc), 32'd4);
`else
    check("sparse_ptr_grant", 32'(acc), 32'd1);
`endif
    repeat (3) step('0, acc);
    check("sparse_drain", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
